// File: rtl/pipe_perf_monitor_if.sv
// Control, event and readout bundle between the CPU-side hazard logic and the
// pipeline performance monitor.
interface pipe_perf_monitor_if #(
  parameter int NUM_EVT = 4,
  parameter int CNT_W   = 32
) ();
  localparam int SEL_W = $clog2(NUM_EVT + 1);

  logic               start_i;
  logic               clr_i;
  logic               freeze_i;
  logic               snap_i;
  logic [NUM_EVT-1:0] evt_i;
  logic [SEL_W-1:0]   rd_sel_i;
  logic [CNT_W-1:0]   rd_data_o;
  logic [CNT_W-1:0]   cycle_o;
  logic               running_o;
  logic               done_o;
  logic [NUM_EVT:0]   ovf_o;

  modport master (
    output start_i, clr_i, freeze_i, snap_i, evt_i, rd_sel_i,
    input  rd_data_o, cycle_o, running_o, done_o, ovf_o
  );

  modport slave (
    input  start_i, clr_i, freeze_i, snap_i, evt_i, rd_sel_i,
    output rd_data_o, cycle_o, running_o, done_o, ovf_o
  );
endinterface

// File: rtl/pipe_perf_monitor.sv
// Pipeline performance monitor: free-running cycle counter plus NUM_EVT event
// counters, gated by start/freeze/limit, with snapshot shadows and a registered read port.
module pipe_perf_monitor #(
  parameter int NUM_EVT    = 4,
  parameter int CNT_W      = 32,
  parameter int SAT_MODE   = 0,
  parameter int MAX_CYCLES = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  pipe_perf_monitor_if.slave   mon
);
  localparam int NCNT = NUM_EVT + 1;
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CYCLES);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q    [NCNT];
  logic [CNT_W-1:0] shadow_q [NCNT];
  logic [CNT_W-1:0] nxt      [NCNT];
  logic [NUM_EVT:0] hit, wrap_hit, ovf_q;
  logic             count_en;
  logic [CNT_W-1:0] rd_mux, rd_data_p1;

  // Returns {overflow, next value}; the top bit flags an increment out of all-ones.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    logic [CNT_W-1:0] nv;
    logic             o;
    nv = v;
    o  = 1'b0;
    if (en) begin
      if (&v) begin
        o = 1'b1;
        if (SAT_MODE == 0) nv = '0;
      end else begin
        nv = v + 1'b1;
      end
    end
    return {o, nv};
  endfunction

  always_comb begin
    count_en = (state_q == RUN) && !mon.freeze_i && !mon.clr_i;
    hit      = {({NUM_EVT{count_en}} & mon.evt_i), count_en};
    wrap_hit = '0;
    for (int k = 0; k < NCNT; k++) begin
      {wrap_hit[k], nxt[k]} = sat_inc(cnt_q[k], hit[k]);
    end
  end

  always_comb begin
    state_d = state_q;
    if (mon.clr_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (mon.start_i) state_d = RUN;
        RUN:     if ((MAX_CYCLES != 0) && count_en && (nxt[0] == MAX_C)) state_d = DONE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Readout mux sees shadows before this edge's snapshot; out-of-range index reads 0.
  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NCNT; k++) begin
      if (32'(mon.rd_sel_i) == k) rd_mux = shadow_q[k];
    end
  end

  // ---- stage p0: state, live counters and sticky overflow ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NCNT; k++) cnt_q[k] <= '0;
      ovf_q <= '0;
    end else if (mon.clr_i) begin
      for (int k = 0; k < NCNT; k++) cnt_q[k] <= '0;
      ovf_q <= '0;
    end else begin
      for (int k = 0; k < NCNT; k++) cnt_q[k] <= nxt[k];
      ovf_q <= ovf_q | wrap_hit;
    end
  end

  // Shadows capture pre-update values, so a snap coinciding with clr keeps the old counts.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NCNT; k++) shadow_q[k] <= '0;
    end else if (mon.snap_i) begin
      for (int k = 0; k < NCNT; k++) shadow_q[k] <= cnt_q[k];
    end
  end

  // ---- stage p1: registered read port ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rd_data_p1 <= '0;
    else       rd_data_p1 <= rd_mux;
  end

  assign mon.rd_data_o = rd_data_p1;
  assign mon.cycle_o   = cnt_q[0];
  assign mon.running_o = (state_q == RUN);
  assign mon.done_o    = (state_q == DONE);
  assign mon.ovf_o     = ovf_q;
endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Directed bench for pipe_perf_monitor: an integer-level model of the main
// instance checked every cycle, plus literal expectations for each scenario.
module tb_pipe_perf_monitor;
  localparam int M_W  = 8;
  localparam int LIM  = 1 << M_W;
  localparam int MAXC = 20;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       start, clr, frz, snap;
  logic [1:0] evt, sel;

  int n_cmp = 0;
  int n_bad = 0;

  pipe_perf_monitor_if #(.NUM_EVT(2), .CNT_W(8)) m_if ();
  pipe_perf_monitor_if #(.NUM_EVT(2), .CNT_W(4)) s0_if ();
  pipe_perf_monitor_if #(.NUM_EVT(2), .CNT_W(4)) s1_if ();

  assign m_if.start_i  = start; assign s0_if.start_i  = start; assign s1_if.start_i  = start;
  assign m_if.clr_i    = clr;   assign s0_if.clr_i    = clr;   assign s1_if.clr_i    = clr;
  assign m_if.freeze_i = frz;   assign s0_if.freeze_i = frz;   assign s1_if.freeze_i = frz;
  assign m_if.snap_i   = snap;  assign s0_if.snap_i   = snap;  assign s1_if.snap_i   = snap;
  assign m_if.evt_i    = evt;   assign s0_if.evt_i    = evt;   assign s1_if.evt_i    = evt;
  assign m_if.rd_sel_i = sel;   assign s0_if.rd_sel_i = sel;   assign s1_if.rd_sel_i = sel;

  pipe_perf_monitor #(.NUM_EVT(2), .CNT_W(8), .SAT_MODE(0), .MAX_CYCLES(20)) u_main (
    .clk_i(clk_i), .rst_i(rst_i), .mon(m_if));
  pipe_perf_monitor #(.NUM_EVT(2), .CNT_W(4), .SAT_MODE(0), .MAX_CYCLES(0)) u_wrap (
    .clk_i(clk_i), .rst_i(rst_i), .mon(s0_if));
  pipe_perf_monitor #(.NUM_EVT(2), .CNT_W(4), .SAT_MODE(1), .MAX_CYCLES(0)) u_sat (
    .clk_i(clk_i), .rst_i(rst_i), .mon(s1_if));

  always #5 clk_i = ~clk_i;

  // Model of the main instance: st 0=idle, 1=run, 2=done; index 0 = cycles, k = event k-1.
  typedef struct packed {
    logic [1:0]       st;
    logic [2:0]       ovf;
    logic [2:0][31:0] cnt;
    logic [2:0][31:0] sh;
    logic [31:0]      rd;
  } mst_t;

  mst_t m;

  function automatic mst_t step(mst_t cur, logic st_v, logic cl_v, logic fz_v, logic sn_v,
                                logic [1:0] ev_v, logic [1:0] sl_v);
    mst_t       n;
    logic [2:0] h;
    n = cur;
    h = {ev_v, 1'b1};
    n.rd = 32'd0;
    if (sl_v <= 2'd2) n.rd = cur.sh[sl_v];
    if (sn_v) n.sh = cur.cnt;
    if (cl_v) begin
      n.cnt = '0;
      n.ovf = '0;
      n.st  = 2'd0;
    end else if (cur.st == 2'd0) begin
      if (st_v) n.st = 2'd1;
    end else if (cur.st == 2'd1 && !fz_v) begin
      for (int k = 0; k < 3; k++) begin
        if (h[k]) begin
          if (cur.cnt[k] == LIM - 1) n.ovf[k] = 1'b1;
          n.cnt[k] = (cur.cnt[k] + 1) % LIM;
        end
      end
      if (n.cnt[0] == MAXC) n.st = 2'd2;
    end
    return n;
  endfunction

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) m <= '0;
    else       m <= step(m, start, clr, frz, snap, evt, sel);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin
    check("model_cycle",   32'(m_if.cycle_o),   m.cnt[0]);
    check("model_running", 32'(m_if.running_o), 32'(m.st == 2'd1));
    check("model_done",    32'(m_if.done_o),    32'(m.st == 2'd2));
    check("model_ovf",     32'(m_if.ovf_o),     32'(m.ovf));
    check("model_rd",      32'(m_if.rd_data_o), m.rd);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    #2 rst_i = 1'b1;
    start = 0; clr = 0; frz = 0; snap = 0; evt = 0; sel = 0;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    start = 0; clr = 0; frz = 0; snap = 0; evt = 0; sel = 0;
    #1 rst_i = 1'b1;
    @(negedge clk_i);
    check("reset_cycle", 32'(m_if.cycle_o), 0);
    check("reset_ovf",   32'(m_if.ovf_o), 0);
    rst_i = 1'b0;

    // Limit stop, then start ignored in DONE
    do_reset();
    start = 1; tick(); start = 0;
    tick(20);
    check("t1_cycle", 32'(m_if.cycle_o), 20);
    check("t1_done", 32'(m_if.done_o), 1);
    check("t1_running", 32'(m_if.running_o), 0);
    start = 1; tick(10); start = 0;
    check("t1_hold_cycle", 32'(m_if.cycle_o), 20);
    check("t1_hold_done", 32'(m_if.done_o), 1);

    // Event counts and read port
    do_reset();
    start = 1; tick(); start = 0;
    for (int i = 0; i < 20; i++) begin
      evt = {1'(i % 2 == 0), 1'b1};
      tick();
    end
    evt = 0;
    check("t2_done", 32'(m_if.done_o), 1);
    snap = 1; sel = 2'd1; tick(); snap = 0; tick();
    check("t2_rd_evt0", 32'(m_if.rd_data_o), 20);
    sel = 2'd2; tick();
    check("t2_rd_evt1", 32'(m_if.rd_data_o), 10);
    sel = 2'd0; tick();
    check("t2_rd_cycle", 32'(m_if.rd_data_o), 20);
    sel = 2'd3; tick();
    check("t2_rd_oob", 32'(m_if.rd_data_o), 0);

    // Freeze for 5 edges mid-RUN
    do_reset();
    start = 1; tick(); start = 0;
    evt = 2'b01;
    for (int i = 0; i < 25; i++) begin
      frz = (i >= 7 && i < 12);
      if (i == 24) check("t3_not_done_yet", 32'(m_if.done_o), 0);
      tick();
    end
    frz = 0; evt = 0;
    check("t3_done", 32'(m_if.done_o), 1);
    check("t3_cycle", 32'(m_if.cycle_o), 20);
    snap = 1; sel = 2'd1; tick(); snap = 0; tick();
    check("t3_rd_evt0", 32'(m_if.rd_data_o), 20);

    // Overflow on 4-bit instances, wrap and saturate
    do_reset();
    start = 1; tick(); start = 0;
    evt = 2'b01; tick(20); evt = 0;
    check("t4_wrap_cycle", 32'(s0_if.cycle_o), 4);
    check("t4_wrap_ovf", 32'(s0_if.ovf_o), 3);
    check("t4_sat_cycle", 32'(s1_if.cycle_o), 15);
    check("t4_sat_ovf", 32'(s1_if.ovf_o), 3);
    snap = 1; sel = 2'd1; tick(); snap = 0; tick();
    check("t4_wrap_evt0", 32'(s0_if.rd_data_o), 4);
    check("t4_sat_evt0", 32'(s1_if.rd_data_o), 15);

    // Clear and snap on the same edge
    do_reset();
    start = 1; tick(); start = 0;
    evt = 2'b11; tick(7); evt = 0;
    check("t5_pre_cycle", 32'(m_if.cycle_o), 7);
    clr = 1; snap = 1; sel = 2'd0; tick(); clr = 0; snap = 0;
    check("t5_cycle", 32'(m_if.cycle_o), 0);
    check("t5_ovf", 32'(m_if.ovf_o), 0);
    check("t5_running", 32'(m_if.running_o), 0);
    check("t5_done", 32'(m_if.done_o), 0);
    tick();
    check("t5_shadow", 32'(m_if.rd_data_o), 7);
    start = 1; tick(); start = 0; tick(3);
    check("t5_restart", 32'(m_if.cycle_o), 3);

    // Asynchronous reset mid-RUN
    do_reset();
    start = 1; tick(); start = 0;
    tick(2);
    snap = 1; sel = 2'd0; tick(); snap = 0;
    tick(2);
    check("t6_pre_rd", 32'(m_if.rd_data_o), 2);
    check("t6_pre_running", 32'(m_if.running_o), 1);
    #2 rst_i = 1'b1;
    #1;
    check("t6_cycle", 32'(m_if.cycle_o), 0);
    check("t6_rd", 32'(m_if.rd_data_o), 0);
    check("t6_running", 32'(m_if.running_o), 0);
    check("t6_ovf", 32'(m_if.ovf_o), 0);
    #1 rst_i = 1'b0;
    tick();
    check("t6_idle", 32'(m_if.running_o), 0);
    check("t6_idle_cycle", 32'(m_if.cycle_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pipe_perf_monitor.md
# pipe_perf_monitor

Synthesizable pipeline performance monitor, the in-hardware successor to bench-side stall and flush counting. It counts a free-running cycle count and NUM_EVT independent event lines (stall, flush, load-use, and so on) from the CPU. Counters are gated by start, freeze and an optional cycle limit, with selectable wrap or saturate behaviour. Snapshot shadow registers allow coherent readout through a registered read port. It sits beside CPU, fed by hazard-detection and control signals.

## Interface
- NUM_EVT, 4: number of event channels (1..15).
- CNT_W, 32: width of every counter (4..32).
- SAT_MODE, 0: 0 = counters wrap at 2^CNT_W; 1 = counters saturate at 2^CNT_W-1.
- MAX_CYCLES, 0: cycle limit that moves the block to DONE. 0 disables the limit. Must be < 2^CNT_W.
- clk_i, in, 1: clock, rising edge.
- rst_i, in, 1: asynchronous, active-high reset.
- start_i, in, 1: begin counting; sampled in IDLE only.
- clr_i, in, 1: synchronous clear of live counters, ovf_o and state.
- freeze_i, in, 1: suppresses all counting on edges where it is sampled high.
- snap_i, in, 1: copies all live counters into shadow registers.
- evt_i, in, NUM_EVT: event strobes; bit i counts into event counter i.
- rd_sel_i, in, SEL_W = $clog2(NUM_EVT+1): read index. 0 = cycle counter; k = event counter k-1.
- rd_data_o, out, CNT_W: registered shadow[rd_sel_i].
- cycle_o, out, CNT_W: live cycle counter.
- running_o, out, 1: state == RUN.
- done_o, out, 1: state == DONE.
- ovf_o, out, NUM_EVT+1: sticky overflow flags. Bit 0 is the cycle counter; bit k+1 is event k.

## Operation
- States are IDLE, RUN and DONE.
- Reset state is IDLE. All live counters, shadows, rd_data_o, ovf_o, running_o and done_o are 0.
- IDLE -> RUN on an edge sampling start_i=1. Nothing is counted on that edge.
- A counting edge is an edge where the state is RUN, freeze_i=0 and clr_i=0. On a counting edge:
  - the cycle counter increments by 1;
  - each event counter i increments by 1 if evt_i[i]=1.
- Overflow handling:
  - An increment from 2^CNT_W-1 sets the matching ovf_o bit (sticky).
  - With SAT_MODE=0 the counter wraps to 0.
  - With SAT_MODE=1 the counter holds 2^CNT_W-1.
- RUN -> DONE on the counting edge where the cycle counter becomes MAX_CYCLES (MAX_CYCLES≠0). Events on that edge are counted.
- In DONE all counters hold and start_i is ignored. The block leaves DONE only via clr_i or rst_i.
- start_i in RUN is ignored. freeze_i in IDLE or DONE has no effect.
- clr_i, in any state:
  - live counters and ovf_o go to 0;
  - state goes to IDLE;
  - shadows are untouched.
- snap_i, in any state: each shadow takes the live counter value from before the same edge's update (pre-increment, pre-clear).
- snap_i and clr_i on the same edge: the shadow gets the pre-clear values and the live counters clear.
- rd_data_o is loaded every edge with the shadow at rd_sel_i, using the shadow value before the same edge's snapshot. An out-of-range rd_sel_i gives 0.

## Timing
- Latency from an event to the counter is 1 edge: the counter reflects evt_i sampled at edge N immediately after edge N.
- Latency from start_i to the first count is 2 edges: the first counting edge is the edge after the one that samples start_i.
- done_o asserts immediately after the edge that brings the cycle counter to MAX_CYCLES. running_o deasserts at the same time.
- Snapshot to readout is 2 edges: snap at edge N, shadow valid after N, rd_data_o shows it after edge N+1 (rd_sel_i held).
- rst_i asynchronously forces all outputs to 0 at any time, including mid-RUN, independent of the clock.
- The first edge after rst_i deasserts behaves as IDLE.

## Test plan
Unless stated otherwise: NUM_EVT=2, CNT_W=8, SAT_MODE=0, MAX_CYCLES=20.
1. Limit stop: reset, start_i=1 for one edge, evt_i=0 → after 20 counting edges done_o=1, running_o=0, cycle_o=20. Values hold for 10 more edges with start_i=1.
2. Event counts: evt_i[0]=1 every cycle, evt_i[1] toggling from 1 → at DONE, snap_i, then rd_sel_i=1 gives rd_data_o=20 two edges after the snap. rd_sel_i=2 gives 10, rd_sel_i=0 gives 20, rd_sel_i=3 gives 0.
3. Freeze: freeze_i=1 for 5 edges mid-RUN with evt_i[0]=1 → done_o rises 25 edges after start, cycle_o=20, event counter 0 = 20.
4. Overflow: CNT_W=4, MAX_CYCLES=0, evt_i[0]=1 for 20 counting edges.
   - SAT_MODE=0 → cycle_o=4, counter 0 = 4, ovf_o=3'b011.
   - SAT_MODE=1 → cycle_o=15, counter 0 = 15, ovf_o=3'b011.
5. Clear and snap collision: clr_i=1 and snap_i=1 on the edge where cycle_o=7 → shadow cycle = 7, cycle_o=0, ovf_o=0, IDLE. A new start_i restarts the count from 0.
6. Async reset: rst_i pulsed mid-RUN between clock edges → cycle_o, rd_data_o, running_o and ovf_o are 0 before the next edge, and the state is IDLE.
